// File: rtl/ofdm_rx_framer.sv
// ofdm_rx_framer
//   Receive-side front end of the N-point 16-QAM OFDM chain. It takes
//   offset-binary ADC samples and converts them to signed complex words
//   (imaginary part zero). It aligns the samples to symbol boundaries on
//   frame_start and buffers them in a first-word-fall-through FIFO that
//   feeds the forward xfft core over AXI-Stream. The FFT forward-transform
//   config word is issued once after every reset.
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   adc_sample/adc_valid   offset-binary sample and its strobe (no backpressure)
//   frame_start            marks adc_sample as index 0 of a symbol
//   m_axis_config_*        one-shot FFT config word channel
//   m_axis_data_*          {real, imag} sample stream, tlast on index NFFT-1
//   overflow               sticky flag: a sample was dropped on a full FIFO
//   symbol_count           number of tlast beats accepted by the FFT (wraps)
module ofdm_rx_framer #(
  parameter int          NFFT     = 8,
  parameter int          FIFO_AW  = 4,
  parameter logic [23:0] CFG_WORD = 24'h140004,
  parameter int          FWD_BIT  = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] adc_sample,
  input  logic        adc_valid,
  input  logic        frame_start,
  output logic [23:0] m_axis_config_tdata,
  output logic        m_axis_config_tvalid,
  input  logic        m_axis_config_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  output logic        m_axis_data_tlast,
  input  logic        m_axis_data_tready,
  output logic        overflow,
  output logic [15:0] symbol_count
);

  localparam int                 IW       = $clog2(NFFT);
  localparam int                 DEPTH    = 2 ** FIFO_AW;
  localparam logic [IW-1:0]      LAST_IDX = IW'(NFFT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CFG    = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  state_e             state_r, state_nxt_s;
  logic [32:0]        mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [IW-1:0]      idx_r, wr_idx_s;
  logic               overflow_r;
  logic [15:0]        symbol_count_r;
  logic               accept_s, push_s, pop_s, drop_s, full_s, data_valid_s;
  logic [32:0]        wr_word_s, head_s;

  assign data_valid_s = (count_r != {(FIFO_AW + 1){1'b0}});
  assign full_s       = (count_r == FULL_CNT);
  assign pop_s        = data_valid_s & m_axis_data_tready;
  // A full FIFO can still take a sample when the head leaves in the same cycle.
  assign push_s       = accept_s & (~full_s | pop_s);
  assign drop_s       = accept_s & full_s & ~pop_s;
  // Offset binary to two's complement: flipping the MSB subtracts 0x8000.
  assign wr_word_s    = {(wr_idx_s == LAST_IDX), adc_sample ^ 16'h8000, 16'h0000};
  assign head_s       = mem_r[rd_ptr_r];

  assign m_axis_config_tdata  = CFG_WORD | (24'd1 << FWD_BIT);
  assign m_axis_config_tvalid = (state_r == ST_CFG);
  assign m_axis_data_tdata    = head_s[31:0];
  assign m_axis_data_tvalid   = data_valid_s;
  assign m_axis_data_tlast    = data_valid_s & head_s[32];
  assign overflow             = overflow_r;
  assign symbol_count         = symbol_count_r;

  // Next-state and write-acceptance decode for the CFG -> ALIGN -> STREAM sequence.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    wr_idx_s    = idx_r;
    case (state_r)
      ST_CFG: begin
        if (m_axis_config_tready) begin
          state_nxt_s = ST_ALIGN;
        end else begin
          state_nxt_s = ST_CFG;
        end
      end
      ST_ALIGN: begin
        if (adc_valid && frame_start) begin
          accept_s    = 1'b1;
          wr_idx_s    = {IW{1'b0}};
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_ALIGN;
        end
      end
      ST_STREAM: begin
        accept_s = adc_valid;
      end
      default: begin
        state_nxt_s = ST_CFG;
      end
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= ST_CFG;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO pointers, occupancy and symbol index; a dropped sample leaves the index unchanged.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= {(FIFO_AW + 1){1'b0}};
      idx_r    <= {IW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
        idx_r    <= wr_idx_s + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage, {tlast, tdata} per entry.
  always_ff @(posedge aclk) begin
    if (aresetn && push_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // Sticky overflow flag and count of completed symbols.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      overflow_r     <= 1'b0;
      symbol_count_r <= 16'd0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (pop_s && head_s[32]) begin
        symbol_count_r <= symbol_count_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_rx_framer.sv
// tb_ofdm_rx_framer
//   Self-checking bench for ofdm_rx_framer: a directed vector table, hand
//   sequences for stalls, overflow and mid-symbol reset, then random traffic.
//   A queue-based reference model is compared with the DUT after every edge.
module tb_ofdm_rx_framer;

  localparam int NFFT  = 8;
  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] adc_sample = 16'h0000;
  logic        adc_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [23:0] m_axis_config_tdata;
  logic        m_axis_config_tvalid;
  logic        m_axis_config_tready = 1'b0;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tlast;
  logic        m_axis_data_tready = 1'b0;
  logic        overflow;
  logic [15:0] symbol_count;

  ofdm_rx_framer dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .adc_sample           (adc_sample),
    .adc_valid            (adc_valid),
    .frame_start          (frame_start),
    .m_axis_config_tdata  (m_axis_config_tdata),
    .m_axis_config_tvalid (m_axis_config_tvalid),
    .m_axis_config_tready (m_axis_config_tready),
    .m_axis_data_tdata    (m_axis_data_tdata),
    .m_axis_data_tvalid   (m_axis_data_tvalid),
    .m_axis_data_tlast    (m_axis_data_tlast),
    .m_axis_data_tready   (m_axis_data_tready),
    .overflow             (overflow),
    .symbol_count         (symbol_count)
  );

  always #5 aclk = ~aclk;

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [32:0] mq[$];
  bit          m_cfg = 1'b1;
  bit          m_aligned = 1'b0;
  int          m_idx = 0;
  bit          m_ovf = 1'b0;
  int          m_sym = 0;

  task automatic model_step();
    bit          pop;
    logic [15:0] re;
    if (!aresetn) begin
      mq.delete();
      m_cfg = 1'b1; m_aligned = 1'b0; m_idx = 0; m_ovf = 1'b0; m_sym = 0;
    end else begin
      pop = (mq.size() != 0) && m_axis_data_tready;
      if (m_cfg) begin
        if (m_axis_config_tready) m_cfg = 1'b0;
      end else if (adc_valid && (m_aligned || frame_start)) begin
        if (!m_aligned) begin
          m_aligned = 1'b1;
          m_idx = 0;
        end
        if (mq.size() == DEPTH && !pop) begin
          m_ovf = 1'b1;
        end else begin
          re = adc_sample - 16'h8000;
          mq.push_back({(m_idx == NFFT - 1), re, 16'h0000});
          m_idx = (m_idx + 1) % NFFT;
        end
      end
      if (pop) begin
        if (mq[0][32]) m_sym = (m_sym + 1) % 65536;
        void'(mq.pop_front());
      end
    end
  endtask

  task automatic model_check();
    chk("cfg_tvalid", 64'(m_axis_config_tvalid), 64'(m_cfg));
    chk("cfg_tdata", 64'(m_axis_config_tdata), 64'h140104);
    chk("tvalid", 64'(m_axis_data_tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("tdata", 64'(m_axis_data_tdata), 64'(mq[0][31:0]));
      chk("tlast", 64'(m_axis_data_tlast), 64'(mq[0][32]));
    end else begin
      chk("tlast_idle", 64'(m_axis_data_tlast), 64'd0);
    end
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("symbol_count", 64'(symbol_count), 64'(m_sym));
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
    cyc++;
    model_check();
  endtask

  task automatic set_in(input logic rst_n, input logic cfg_rdy, input logic vld,
                        input logic fs, input logic [15:0] smp, input logic rdy);
    aresetn = rst_n; m_axis_config_tready = cfg_rdy; adc_valid = vld;
    frame_start = fs; adc_sample = smp; m_axis_data_tready = rdy;
  endtask

  // Reset, complete the config handshake at once; the next sample can carry frame_start.
  task automatic start_stream();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    m_axis_config_tready = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n, cfg_rdy, vld, fs;
    logic [15:0] smp;
    logic        rdy;
    logic        e_cfg, e_tv;
    logic [31:0] e_data;
    logic        e_last, e_ovf;
    logic [15:0] e_sym;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic cfg_rdy, logic vld, logic fs, logic [15:0] smp,
                              logic rdy, logic e_cfg, logic e_tv, logic [31:0] e_data,
                              logic e_last, logic e_ovf, logic [15:0] e_sym);
    vec_t v;
    v.rst_n = rst_n; v.cfg_rdy = cfg_rdy; v.vld = vld; v.fs = fs; v.smp = smp; v.rdy = rdy;
    v.e_cfg = e_cfg; v.e_tv = e_tv; v.e_data = e_data; v.e_last = e_last; v.e_ovf = e_ovf;
    v.e_sym = e_sym;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    int beats;
    logic [15:0] last_mask;

    // Config held off for 5 cycles after reset, then accepted; samples in CFG/ALIGN dropped.
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0AAA, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0BBB, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0CCC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k < 8; k++) begin
      // frame_start on index 3 must be ignored while streaming.
      tbl[10 + k] = mk(1'b1, 1'b0, 1'b1, (k == 3), 16'(k), 1'b1, 1'b0, 1'b1,
                       {16'h8000 + 16'(k), 16'h0000}, (k == 7), 1'b0, 16'd0);
    end
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd1);
    tbl[19] = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 32'h7FFF0000, 1'b0, 1'b0, 16'd1);
    tbl[20] = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 16'd1);
    tbl[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd1);

    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].rst_n, tbl[i].cfg_rdy, tbl[i].vld, tbl[i].fs, tbl[i].smp, tbl[i].rdy);
      tick();
      chk($sformatf("vec%0d_cfg_tvalid", i), 64'(m_axis_config_tvalid), 64'(tbl[i].e_cfg));
      chk($sformatf("vec%0d_tvalid", i), 64'(m_axis_data_tvalid), 64'(tbl[i].e_tv));
      if (tbl[i].e_tv) begin
        chk($sformatf("vec%0d_tdata", i), 64'(m_axis_data_tdata), 64'(tbl[i].e_data));
        chk($sformatf("vec%0d_tlast", i), 64'(m_axis_data_tlast), 64'(tbl[i].e_last));
      end
      chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_symcnt", i), 64'(symbol_count), 64'(tbl[i].e_sym));
    end

    // 24 back-to-back samples with tready toggling every cycle.
    start_stream();
    for (int i = 0; i < 24; i++) begin
      set_in(1'b1, 1'b0, 1'b1, (i == 0), 16'($urandom), (i % 2 == 0));
      tick();
    end
    adc_valid = 1'b0; frame_start = 1'b0; m_axis_data_tready = 1'b1;
    repeat (20) tick();
    chk("toggle_symcnt", 64'(symbol_count), 64'd3);
    chk("toggle_overflow", 64'(overflow), 64'd0);

    // Fill with tready low: the 17th sample is dropped, then drain 16 entries.
    m_axis_data_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      adc_valid = 1'b1; adc_sample = 16'(16'h0100 + i);
      tick();
    end
    adc_valid = 1'b0;
    chk("fill_overflow", 64'(overflow), 64'd1);
    m_axis_data_tready = 1'b1;
    beats = 0; last_mask = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      if (m_axis_data_tvalid) begin
        if (m_axis_data_tlast && beats < 16) last_mask[beats] = 1'b1;
        beats++;
      end
      tick();
    end
    chk("drain_beats", 64'(beats), 64'd16);
    chk("drain_tlast_pos", 64'(last_mask), 64'h8080);
    chk("drain_symcnt", 64'(symbol_count), 64'd5);
    chk("drain_overflow_sticky", 64'(overflow), 64'd1);

    // Reset with 5 entries buffered in mid-symbol.
    m_axis_data_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1; adc_sample = 16'($urandom);
      tick();
    end
    chk("pre_reset_tvalid", 64'(m_axis_data_tvalid), 64'd1);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h4444, 1'b0);
    tick();
    chk("rst_tvalid", 64'(m_axis_data_tvalid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_symcnt", 64'(symbol_count), 64'd0);
    chk("rst_cfg_tvalid", 64'(m_axis_config_tvalid), 64'd1);

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 399) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 7) == 0), 16'($urandom),
             (i % 500 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0));
      tick();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
